fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch sequencer that sits directly downstream of the program counter register. It enables the PC onto the B bus, issues a handshaked memory read at that address, and captures the returned word into an instruction register. It presents the instruction to the decoder with a valid/ready handshake, and writes the next PC value back, either increment or branch target. It is the only agent that asserts the PC load strobe during normal execution.

## Interface
- `WIDTH`, 16: address/data width.
- `TIMEOUT`, 15: max wait cycles for `mem_ack` before fault (1..255).
- Reset is asynchronous and active-high on `reset`; the clock is `clk`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pc_in` in WIDTH: PC value from the B bus, valid while `pc_oe`=1.
- `pc_oe` out 1: drives the PC output-enable B.
- `pc_ld` out 1: PC load strobe.
- `pc_next` out WIDTH: PC load data.
- `mem_addr` out WIDTH: read address (registered).
- `mem_rd` out 1: read request.
- `mem_ack` in 1: read data valid, single-cycle pulse.
- `mem_data` in WIDTH: read data, sampled when `mem_ack`=1.
- `ir_out` out WIDTH: instruction register.
- `ir_valid` out 1: `ir_out` holds an unconsumed instruction.
- `ir_ready` in 1: decoder accepts.
- `br_req` in 1: branch taken; sampled only at the accept cycle.
- `br_target` in WIDTH: branch target address.
- `halt` in 1: stop fetching after the current instruction is accepted.
- `fetch_err` out 1: sticky timeout fault.

## Operation
- States: `S_ADDR`, `S_WAIT`, `S_HOLD`, `S_HALT`. Reset state is `S_ADDR`.
- `S_ADDR`:
  - `pc_oe`=1; `mem_addr` <= `pc_in`.
  - If `halt`=1, go to `S_HALT`; otherwise go to `S_WAIT`.
- `S_WAIT`:
  - `mem_rd`=1. `mem_rd` is a Moore output decoded from the state register.
  - Wait counter increments each cycle.
  - On `mem_ack`: `ir_out` <= `mem_data`, `ir_valid` <= 1, `pc_ld`=1, `pc_next`=`mem_addr`+1. Go to `S_HOLD`.
  - If the counter reaches `TIMEOUT` without `mem_ack`: `fetch_err` <= 1, go to `S_HALT`, no PC load.
- `S_HOLD`:
  - `ir_valid`=1; `ir_out` is stable.
  - On `ir_ready`=1: `ir_valid` <= 0.
  - If `br_req` is also 1: `pc_ld`=1, `pc_next`=`br_target`.
  - Then go to `S_HALT` if `halt`=1, else `S_ADDR`.
- `S_HALT`:
  - All strobes are 0.
  - Go to `S_ADDR` when `halt`=0 and `fetch_err`=0.
  - `fetch_err` is cleared only by `reset`.
- Increment wraps: 16'hFFFF + 1 = 16'h0000, with no carry out.
- Only one `pc_ld` occurs per cycle. The increment load and the branch load are in different states, so they never coincide.
- `mem_ack` outside `S_WAIT` is ignored.

## Timing
- Reset values: `pc_oe`=0, `pc_ld`=0, `pc_next`=0, `mem_addr`=0, `mem_rd`=0, `ir_out`=0, `ir_valid`=0, `fetch_err`=0. The wait counter is 0.
- `pc_ld` and `pc_next` are Mealy outputs, combinational from the state and inputs. The PC captures them on the same edge that leaves `S_WAIT` or `S_HOLD`.
- Best-case fetch, with `mem_ack` arriving the first cycle of `S_WAIT`: `S_ADDR`, `S_WAIT`, then `ir_valid` is high on cycle 3.
- Best-case throughput with `ir_ready` held high: one instruction per 3 cycles.
- The `S_ADDR` of the next fetch reads the already-updated PC, either increment or branch.
- `mem_rd` remains asserted continuously until the `mem_ack` cycle inclusive. It deasserts the cycle after.
- `TIMEOUT`=N means the fault is set on the Nth `S_WAIT` cycle without ack.
- Reset mid-operation:
  - Asynchronous; the state returns to `S_ADDR` and outputs go to their reset values immediately.
  - An outstanding memory read is abandoned. A late `mem_ack` is ignored because the state is `S_ADDR`.

## Structure
- The shared package `cpu_pkg` holds the `WIDTH` constant and the fetch state enum (`S_ADDR`, `S_WAIT`, `S_HOLD`, `S_HALT`), so the decoder and testbench can reference them.
- One natural sub-module, `wait_timer`: a loadable down-counter with a terminal flag, parameterised by `TIMEOUT`, reused for other bus masters. Everything else stays in `fetch_unit`.

## Test plan
- Basic fetch:
  - Stimulus: after reset, `pc_in`=16'h0010; `mem_ack` on the first `S_WAIT` cycle with `mem_data`=16'hA5A5; `ir_ready`=1.
  - Required response: `mem_addr`=16'h0010; `ir_out`=16'hA5A5; `pc_ld` pulses with `pc_next`=16'h0011; `ir_valid` is high exactly one cycle.
- Wrap:
  - Stimulus: `pc_in`=16'hFFFF.
  - Required response: `pc_next`=16'h0000 at ack.
- Branch:
  - Stimulus: `ir_ready`=1, `br_req`=1, `br_target`=16'h0200 in `S_HOLD`.
  - Required response: second `pc_ld` with 16'h0200; the next `mem_addr` is 16'h0200 (PC model in the bench).
- Backpressure:
  - Stimulus: `ir_ready`=0 for 5 cycles.
  - Required response: `ir_valid` and `ir_out` stable; `mem_rd`=0; no `pc_ld`.
- Timeout:
  - Stimulus: `TIMEOUT`=4, no `mem_ack`.
  - Required response: `fetch_err`=1 after 4 `S_WAIT` cycles; `S_HALT` persists with `halt`=0; cleared only by `reset`.
- Reset mid-wait:
  - Stimulus: assert `reset` during `S_WAIT`, then issue `mem_ack` after release.
  - Required response: `mem_rd` drops immediately; the stray `mem_ack` produces no `ir_valid` and no `pc_ld`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_wait_timer.sv
// Loadable down-counter with a terminal flag; bounds how long a bus master waits for an ack.
module wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Loading TIMEOUT-1 makes the flag rise on the TIMEOUT-th enabled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = CW'(TIMEOUT - 1);
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: reads the PC, fetches one word, holds it for the decoder,
// and writes back either PC+1 or a branch target.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH   = cpu_pkg::WIDTH,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_oe,
    output logic             pc_ld,
    output logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] ir_out,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_target,
    input  logic             halt,
    output logic             fetch_err
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic             ir_valid_q, ir_valid_d;
    logic             err_q, err_d;
    logic             tmr_load, tmr_en, tmr_expired;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        err_d      = err_q;
        pc_ld      = 1'b0;
        pc_next    = '0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        // S_ADDR is also the reset state, so the bus enable is masked while reset is held.
        pc_oe      = (state_q == S_ADDR) && !reset;
        mem_rd     = (state_q == S_WAIT);

        case (state_q)
            S_ADDR: begin
                mem_addr_d = pc_in;
                tmr_load   = 1'b1;
                state_d    = halt ? S_HALT : S_WAIT;
            end
            S_WAIT: begin
                tmr_en = 1'b1;
                if (mem_ack) begin
                    ir_d       = mem_data;
                    ir_valid_d = 1'b1;
                    pc_ld      = 1'b1;
                    pc_next    = mem_addr_q + WIDTH'(1);
                    state_d    = S_HOLD;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_HOLD: begin
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    if (br_req) begin
                        pc_ld   = 1'b1;
                        pc_next = br_target;
                    end
                    state_d = halt ? S_HALT : S_ADDR;
                end
            end
            S_HALT: begin
                if (!halt && !err_q)
                    state_d = S_ADDR;
            end
            default: state_d = S_ADDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_ADDR;
            mem_addr_q <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign ir_out    = ir_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and memory responder around the DUT, a transaction-level
// expectation model checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc_in;
    logic        pc_oe, pc_ld, mem_rd, ir_valid, fetch_err;
    logic [15:0] pc_next, mem_addr, ir_out;
    logic        mem_ack;
    logic [15:0] mem_data = 16'h0;
    logic        ir_ready = 1'b1;
    logic        br_req = 1'b0;
    logic [15:0] br_target = 16'h0;
    logic        halt = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_oe(pc_oe), .pc_ld(pc_ld),
        .pc_next(pc_next), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack),
        .mem_data(mem_data), .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .br_req(br_req), .br_target(br_target), .halt(halt), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return a ^ 16'hA5B5;
    endfunction

    // PC register on the B bus: captures the strobe seen just before each rising edge.
    logic [15:0] pc_reg = 16'h0;
    logic        pc_wr_en = 1'b0;
    logic [15:0] pc_wr_val = 16'h0;
    logic        ld_s = 1'b0;
    logic [15:0] nx_s = 16'h0;
    assign pc_in = pc_reg;

    always @(negedge clk) begin
        #3;
        ld_s = pc_ld;
        nx_s = pc_next;
    end

    always @(posedge clk) begin
        if (pc_wr_en)  pc_reg <= pc_wr_val;
        else if (ld_s) pc_reg <= nx_s;
    end

    // Memory: acks on the ack_dly-th cycle of an active read (0 = never).
    int   ack_dly = 1;
    int   rd_cnt = 0;
    logic resp_ack = 1'b0;
    logic stray_ack = 1'b0;
    assign mem_ack = resp_ack | stray_ack;

    always @(negedge clk) begin
        if (mem_rd) begin
            rd_cnt = rd_cnt + 1;
            if (rd_cnt == ack_dly) begin
                resp_ack = 1'b1;
                mem_data = mem_fn(mem_addr);
            end else begin
                resp_ack = 1'b0;
            end
        end else begin
            rd_cnt   = 0;
            resp_ack = 1'b0;
        end
    end

    // Expectation model: tracks which phase of a fetch transaction is pending.
    logic        m_oe = 1'b0, m_wait = 1'b0, m_valid = 1'b0, m_err = 1'b0, m_halted = 1'b0;
    logic        m_achk = 1'b0;
    logic [15:0] m_addr = 16'h0, m_ir = 16'h0;
    int          m_wcnt = 0;

    always @(negedge clk) begin
        logic        exp_ld, n_oe, n_wait, n_valid, n_halted;
        logic [15:0] inc;
        #3;
        if (reset) begin
            chk("rst_pc_oe", 32'(pc_oe), 0);
            chk("rst_mem_rd", 32'(mem_rd), 0);
            chk("rst_pc_ld", 32'(pc_ld), 0);
            chk("rst_pc_next", 32'(pc_next), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_ir_out", 32'(ir_out), 0);
            chk("rst_ir_valid", 32'(ir_valid), 0);
            chk("rst_fetch_err", 32'(fetch_err), 0);
            m_oe = 1'b1; m_wait = 1'b0; m_valid = 1'b0; m_err = 1'b0;
            m_halted = 1'b0; m_achk = 1'b0; m_wcnt = 0;
        end else begin
            exp_ld = (m_wait && mem_ack) || (m_valid && ir_ready && br_req);
            inc    = m_addr + 16'd1;
            chk("m_pc_oe", 32'(pc_oe), 32'(m_oe));
            chk("m_mem_rd", 32'(mem_rd), 32'(m_wait));
            chk("m_ir_valid", 32'(ir_valid), 32'(m_valid));
            chk("m_fetch_err", 32'(fetch_err), 32'(m_err));
            chk("m_pc_ld", 32'(pc_ld), 32'(exp_ld));
            if (exp_ld)
                chk("m_pc_next", 32'(pc_next), 32'(m_wait ? inc : br_target));
            if (m_achk)
                chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_valid)
                chk("m_ir_out", 32'(ir_out), 32'(m_ir));

            n_oe = 1'b0; n_wait = m_wait; n_valid = m_valid; n_halted = m_halted;
            m_achk = 1'b0;
            if (m_oe) begin
                m_addr = pc_in;
                m_achk = 1'b1;
                if (halt) n_halted = 1'b1;
                else begin n_wait = 1'b1; m_wcnt = 0; end
            end
            if (m_wait) begin
                m_wcnt = m_wcnt + 1;
                if (mem_ack) begin
                    n_wait = 1'b0; n_valid = 1'b1; m_ir = mem_data;
                end else if (m_wcnt == TO) begin
                    n_wait = 1'b0; m_err = 1'b1; n_halted = 1'b1;
                end
            end
            if (m_valid && ir_ready) begin
                n_valid = 1'b0;
                if (halt) n_halted = 1'b1;
                else n_oe = 1'b1;
            end
            if (m_halted && !halt && !m_err) begin
                n_halted = 1'b0; n_oe = 1'b1;
            end
            m_oe = n_oe; m_wait = n_wait; m_valid = n_valid; m_halted = n_halted;
        end
    end

    task automatic step();
        @(negedge clk);
        #4;
    endtask

    task automatic do_reset(input logic [15:0] pc);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        pc_wr_en  = 1'b1;
        pc_wr_val = pc;
        step();
        chk("dr_pc_oe", 32'(pc_oe), 0);
        chk("dr_fetch_err", 32'(fetch_err), 0);
        @(posedge clk);
        #1;
        pc_wr_en = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic fetch
        ack_dly = 1; ir_ready = 1'b1; br_req = 1'b0; halt = 1'b0;
        do_reset(16'h0010);
        step();
        chk("basic_pc_oe", 32'(pc_oe), 1);
        step();
        chk("basic_mem_addr", 32'(mem_addr), 32'h0010);
        chk("basic_mem_rd", 32'(mem_rd), 1);
        chk("basic_pc_ld", 32'(pc_ld), 1);
        chk("basic_pc_next", 32'(pc_next), 32'h0011);
        step();
        chk("basic_ir_valid", 32'(ir_valid), 1);
        chk("basic_ir_out", 32'(ir_out), 32'hA5A5);
        chk("basic_rd_drop", 32'(mem_rd), 0);
        step();
        chk("basic_valid_1cyc", 32'(ir_valid), 0);
        chk("basic_next_pc", 32'(pc_in), 32'h0011);

        // Wrap
        do_reset(16'hFFFF);
        step();
        step();
        chk("wrap_mem_addr", 32'(mem_addr), 32'hFFFF);
        chk("wrap_pc_next", 32'(pc_next), 32'h0000);
        step();
        chk("wrap_ir_out", 32'(ir_out), 32'h5A4A);

        // Branch
        br_req = 1'b1; br_target = 16'h0200;
        do_reset(16'h0100);
        step();
        step();
        chk("br_inc_next", 32'(pc_next), 32'h0101);
        step();
        chk("br_pc_ld", 32'(pc_ld), 1);
        chk("br_pc_next", 32'(pc_next), 32'h0200);
        @(posedge clk);
        #1;
        br_req = 1'b0;
        step();
        chk("br_pc_in", 32'(pc_in), 32'h0200);
        step();
        chk("br_mem_addr", 32'(mem_addr), 32'h0200);
        chk("br_pc_next2", 32'(pc_next), 32'h0201);

        // Backpressure
        ir_ready = 1'b0;
        do_reset(16'h0040);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ir_valid", 32'(ir_valid), 1);
            chk("bp_ir_out", 32'(ir_out), 32'hA5F5);
            chk("bp_mem_rd", 32'(mem_rd), 0);
            chk("bp_pc_ld", 32'(pc_ld), 0);
        end
        @(posedge clk);
        #1;
        ir_ready = 1'b1;
        step();
        step();
        chk("bp_released", 32'(ir_valid), 0);

        // Timeout
        ack_dly = 0;
        do_reset(16'h0080);
        step();
        for (int i = 0; i < TO; i++) begin
            step();
            chk("to_mem_rd", 32'(mem_rd), 1);
            chk("to_err_early", 32'(fetch_err), 0);
        end
        step();
        chk("to_fetch_err", 32'(fetch_err), 1);
        chk("to_rd_drop", 32'(mem_rd), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_sticky", 32'(fetch_err), 1);
            chk("to_halt_oe", 32'(pc_oe), 0);
        end

        // Reset mid-wait with a stray ack afterwards
        do_reset(16'h0090);
        step();
        step();
        chk("rmw_mem_rd", 32'(mem_rd), 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rmw_rd_async", 32'(mem_rd), 0);
        chk("rmw_ld_async", 32'(pc_ld), 0);
        halt = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        stray_ack = 1'b1;
        step();
        chk("rmw_oe", 32'(pc_oe), 1);
        chk("rmw_stray_ld", 32'(pc_ld), 0);
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rmw_no_valid", 32'(ir_valid), 0);
            chk("rmw_no_ld", 32'(pc_ld), 0);
        end
        @(posedge clk);
        #1;
        halt = 1'b0;

        // Streaming run with slower memory and intermittent decoder stalls
        ack_dly = 2;
        do_reset(16'h0300);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            ir_ready  = (i % 3) != 1;
            br_req    = (i == 10);
            br_target = 16'h0700;
        end
        br_req = 1'b0;
        ir_ready = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
